// File: rtl/eeprom_reader_if.sv
// rtl/eeprom_reader_if.sv - signal bundle between the EEPROM reader, the shared EEPROM bus and the egress FIFO
//
// Purpose : groups the start/range request, bus arbitration, EEPROM pins and
//           FIFO write side of the readback engine.
// Signals : start/start_addr/len  range request (len in bytes, 0..2^ADDR_W)
//           busy/done             engine status, done is a one-cycle pulse
//           bus_req/bus_gnt       EEPROM bus arbitration
//           addr/nce/noe/nwe      EEPROM address and active-low strobes
//           data_in               EEPROM read data
//           full/din/wr_en        egress FIFO write port
// Modports: master = reader side, slave = environment side.
interface eeprom_reader_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] addr;
    logic              nce;
    logic              noe;
    logic              nwe;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic [DATA_W-1:0] din;
    logic              wr_en;

    modport master (
        input  start, start_addr, len, bus_gnt, data_in, full,
        output busy, done, bus_req, addr, nce, noe, nwe, din, wr_en
    );

    modport slave (
        output start, start_addr, len, bus_gnt, data_in, full,
        input  busy, done, bus_req, addr, nce, noe, nwe, din, wr_en
    );
endinterface

// File: rtl/eeprom_reader.sv
// rtl/eeprom_reader.sv - EEPROM range readback engine feeding the egress FIFO
//
// Purpose: on start, reads len bytes from start_addr (wrapping at 2^ADDR_W)
//          and pushes each byte into the egress FIFO. Owns the EEPROM bus via
//          bus_req/bus_gnt, never writes the device, stalls on FIFO full.
// Ports  : clk  - system clock, rising edge
//          nrst - synchronous reset, active low
//          bus  - eeprom_reader_if master modport (request, status, EEPROM
//                 pins, FIFO write port); all outputs registered except nwe.
module eeprom_reader #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int ACCESS_CYC = 2
) (
    input  logic            clk,
    input  logic            nrst,
    eeprom_reader_if.master bus
);
    localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ACCESS_CYC - 1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, REQ, SETUP, ACCESS, PUSH, STALL} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;     // also serves as the current byte pointer
    logic              nce_q, nce_d;
    logic              noe_q, noe_d;
    logic [DATA_W-1:0] data_q, data_d;     // holding register, drives din
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   rem_q, rem_d;       // bytes still to be pushed
    logic [CNT_W-1:0]  cnt_q, cnt_d;       // access cycles left before sampling

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_req_q <= 1'b0;
            addr_q    <= '0;
            nce_q     <= 1'b1;
            noe_q     <= 1'b1;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bus_req_q <= bus_req_d;
            addr_q    <= addr_d;
            nce_q     <= nce_d;
            noe_q     <= noe_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bus_req_d = bus_req_q;
        addr_d    = addr_q;
        nce_d     = nce_q;
        noe_d     = noe_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        rem_d     = rem_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d    = bus.start_addr;
                        rem_d     = bus.len;
                        busy_d    = 1'b1;
                        bus_req_d = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.bus_gnt) begin
                    nce_d   = 1'b0;
                    noe_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!bus.bus_gnt) begin
                    nce_d   = 1'b1;
                    noe_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Grant loss wins over the sampling cycle: the byte is
                // abandoned and the same address is re-read after re-grant.
                if (!bus.bus_gnt) begin
                    nce_d   = 1'b1;
                    noe_d   = 1'b1;
                    state_d = REQ;
                end else if (cnt_q == '0) begin
                    data_d = bus.data_in;
                    if (bus.full) begin
                        nce_d   = 1'b1;
                        noe_d   = 1'b1;
                        state_d = STALL;
                    end else begin
                        wr_en_d = 1'b1;
                        done_d  = (rem_q == REM_ONE);
                        state_d = PUSH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STALL: begin
                // bus_req stays high so the page writer cannot interleave.
                if (!bus.full) begin
                    wr_en_d = 1'b1;
                    done_d  = (rem_q == REM_ONE);
                    state_d = PUSH;
                end
            end
            PUSH: begin
                rem_d  = rem_q - 1'b1;
                addr_d = addr_q + ADDR_ONE;
                if (rem_q == REM_ONE) begin
                    busy_d    = 1'b0;
                    bus_req_d = 1'b0;
                    nce_d     = 1'b1;
                    noe_d     = 1'b1;
                    state_d   = IDLE;
                end else if (bus.bus_gnt) begin
                    nce_d   = 1'b0;
                    noe_d   = 1'b0;
                    state_d = SETUP;
                end else begin
                    nce_d   = 1'b1;
                    noe_d   = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bus_req = bus_req_q;
    assign bus.addr    = addr_q;
    assign bus.nce     = nce_q;
    assign bus.noe     = noe_q;
    assign bus.nwe     = 1'b1;
    assign bus.din     = data_q;
    assign bus.wr_en   = wr_en_q;
endmodule

// File: tb/tb_eeprom_reader.sv
// tb/tb_eeprom_reader.sv - self-checking bench for eeprom_reader
module tb_eeprom_reader;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int ACCESS_CYC = 2;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    eeprom_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    eeprom_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYC(ACCESS_CYC)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // EEPROM model: data only valid while selected and output-enabled.
    assign bus.data_in = (!bus.nce && !bus.noe) ? (bus.addr[7:0] ^ 8'h5A) : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  wr_din[$];
    int          wr_cyc[$];
    logic [16:0] acc_addr[$];
    int          done_cyc[$];
    int          wr_full_viol = 0;
    int          nwe_viol     = 0;
    bit          saw_busy, saw_req;
    logic        prev_nce = 1'b1;
    logic [16:0] prev_addr = '0;
    int          t0 = 0;

    typedef struct {
        logic [16:0] sa;
        logic [17:0] ln;
        int          exp_done;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wr_din.delete();
        wr_cyc.delete();
        acc_addr.delete();
        done_cyc.delete();
        saw_busy = 1'b0;
        saw_req  = 1'b0;
    endtask

    // Drive this cycle's inputs (they apply at the coming rising edge), then
    // sample the registered outputs of the current cycle.
    task automatic tick(input logic s, input logic f, input logic g, input logic r);
        @(negedge clk);
        bus.start   = s;
        bus.full    = f;
        bus.bus_gnt = g;
        nrst        = r;
        if (s) t0 = cyc;
        if (bus.wr_en) begin
            wr_din.push_back(bus.din);
            wr_cyc.push_back(cyc - t0);
            if (f) wr_full_viol++;
        end
        if (bus.done) done_cyc.push_back(cyc - t0);
        if (!bus.nce && (prev_nce || bus.addr != prev_addr)) acc_addr.push_back(bus.addr);
        if (bus.nwe !== 1'b1) nwe_viol++;
        if (bus.busy) saw_busy = 1'b1;
        if (bus.bus_req) saw_req = 1'b1;
        prev_nce  = bus.nce;
        prev_addr = bus.addr;
    endtask

    task automatic check_bytes(input string tag, input logic [16:0] sa, input int n);
        check({tag, " write count"}, wr_din.size(), n);
        for (int i = 0; i < n && i < wr_din.size(); i++)
            check($sformatf("%s din[%0d]", tag, i), wr_din[i], 8'(17'(sa + 17'(i))) ^ 8'h5A);
    endtask

    initial begin
        vecs[0] = '{sa: 17'h00010, ln: 18'd4, exp_done: 17, exp_first: 8'h4A, exp_last: 8'h49};
        vecs[1] = '{sa: 17'h1FFFE, ln: 18'd4, exp_done: 17, exp_first: 8'hA4, exp_last: 8'h5B};
        vecs[2] = '{sa: 17'h000A5, ln: 18'd1, exp_done: 5,  exp_first: 8'hFF, exp_last: 8'hFF};
        vecs[3] = '{sa: 17'h12345, ln: 18'd2, exp_done: 9,  exp_first: 8'h1F, exp_last: 8'h1C};
        vecs[4] = '{sa: 17'h00000, ln: 18'd0, exp_done: 1,  exp_first: 8'h00, exp_last: 8'h00};

        bus.start = 1'b0; bus.start_addr = '0; bus.len = '0;
        bus.full = 1'b0; bus.bus_gnt = 1'b1; nrst = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 0);
        check("reset busy",    bus.busy,    0);
        check("reset done",    bus.done,    0);
        check("reset bus_req", bus.bus_req, 0);
        check("reset addr",    bus.addr,    0);
        check("reset nce",     bus.nce,     1);
        check("reset noe",     bus.noe,     1);
        check("reset din",     bus.din,     0);
        check("reset wr_en",   bus.wr_en,   0);
        check("reset nwe",     bus.nwe,     1);
        tick(0, 0, 1, 1);

        // Table-driven unstalled reads with grant held high
        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            clear_logs();
            bus.start_addr = vecs[v].sa;
            bus.len        = vecs[v].ln;
            tick(1, 0, 1, 1);
            for (int k = 1; k <= vecs[v].exp_done + 4; k++) begin
                tick(0, 0, 1, 1);
                if (k == 1) check({tag, " busy after start"}, bus.busy, (vecs[v].ln != 0) ? 1 : 0);
            end
            check({tag, " done pulses"}, done_cyc.size(), 1);
            if (done_cyc.size() > 0) check({tag, " done cycle"}, done_cyc[0], vecs[v].exp_done);
            check_bytes(tag, vecs[v].sa, int'(vecs[v].ln));
            if (vecs[v].ln != 0 && wr_din.size() > 0) begin
                check({tag, " first din"},   wr_din[0], vecs[v].exp_first);
                check({tag, " last din"},    wr_din[wr_din.size()-1], vecs[v].exp_last);
                check({tag, " first wr cyc"}, wr_cyc[0], ACCESS_CYC + 3);
                check({tag, " last wr cyc"},  wr_cyc[wr_cyc.size()-1], vecs[v].exp_done);
                check({tag, " access count"}, acc_addr.size(), int'(vecs[v].ln));
                for (int i = 0; i < acc_addr.size(); i++)
                    check($sformatf("%s addr[%0d]", tag, i), acc_addr[i], 17'(vecs[v].sa + 17'(i)));
                for (int i = 1; i < wr_cyc.size(); i++)
                    check($sformatf("%s wr spacing[%0d]", tag, i), wr_cyc[i] - wr_cyc[i-1], ACCESS_CYC + 2);
            end
            if (vecs[v].ln == 0) begin
                check({tag, " busy seen"},    saw_busy, 0);
                check({tag, " bus_req seen"}, saw_req,  0);
            end
        end

        // FIFO back-pressure: full high for 10 cycles from the first capture
        begin
            int nce_viol, req_viol;
            nce_viol = 0; req_viol = 0;
            clear_logs();
            bus.start_addr = 17'h00020; bus.len = 18'd3;
            tick(1, 0, 1, 1);
            for (int k = 1; k <= 28; k++) begin
                tick(0, (k >= 4 && k <= 13), 1, 1);
                if (k >= 5 && k <= 13 && !(bus.nce && bus.noe)) nce_viol++;
                if (k <= 23 && !bus.bus_req) req_viol++;
            end
            check("stall nce/noe high", nce_viol, 0);
            check("stall bus_req held", req_viol, 0);
            check_bytes("stall", 17'h00020, 3);
            if (wr_cyc.size() == 3) begin
                check("stall wr0 cyc", wr_cyc[0], 15);
                check("stall wr1 cyc", wr_cyc[1], 19);
                check("stall wr2 cyc", wr_cyc[2], 23);
            end
            check("stall done pulses", done_cyc.size(), 1);
            if (done_cyc.size() > 0) check("stall done cyc", done_cyc[0], 23);
        end

        // Grant: low for 6 cycles after start, then dropped in ACCESS of byte 2
        begin
            int nce_viol;
            nce_viol = 0;
            clear_logs();
            bus.start_addr = 17'h00100; bus.len = 18'd3;
            tick(1, 0, 0, 1);
            for (int k = 1; k <= 28; k++) begin
                tick(0, 0, (k >= 6) && !(k >= 12 && k <= 14), 1);
                if ((k <= 6 || (k >= 13 && k <= 15)) && !bus.nce) nce_viol++;
            end
            check("gnt nce high without grant", nce_viol, 0);
            check_bytes("gnt", 17'h00100, 3);
            check("gnt access count", acc_addr.size(), 4);
            if (acc_addr.size() == 4) begin
                check("gnt addr0", acc_addr[0], 17'h00100);
                check("gnt addr1", acc_addr[1], 17'h00101);
                check("gnt addr1 reread", acc_addr[2], 17'h00101);
                check("gnt addr2", acc_addr[3], 17'h00102);
            end
            if (wr_cyc.size() == 3) begin
                check("gnt wr0 cyc", wr_cyc[0], 10);
                check("gnt wr1 cyc", wr_cyc[1], 19);
                check("gnt wr2 cyc", wr_cyc[2], 23);
            end
            check("gnt done pulses", done_cyc.size(), 1);
        end

        // start while busy is ignored
        clear_logs();
        bus.start_addr = 17'h00040; bus.len = 18'd2;
        tick(1, 0, 1, 1);
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) begin
                bus.start_addr = 17'h00000; bus.len = 18'd5;
            end
            tick(k == 3, 0, 1, 1);
        end
        check_bytes("busy-start", 17'h00040, 2);
        check("busy-start done pulses", done_cyc.size(), 1);

        // Reset during ACCESS of byte 2 of 5, then a fresh read
        clear_logs();
        bus.start_addr = 17'h00200; bus.len = 18'd5;
        tick(1, 0, 1, 1);
        for (int k = 1; k <= 20; k++) begin
            tick(0, 0, 1, !(k == 7 || k == 8));
            if (k == 8) begin
                check("rst nce",     bus.nce,     1);
                check("rst noe",     bus.noe,     1);
                check("rst bus_req", bus.bus_req, 0);
                check("rst busy",    bus.busy,    0);
            end
        end
        check("rst writes before reset", wr_din.size(), 1);
        check("rst done pulses", done_cyc.size(), 0);
        clear_logs();
        bus.start_addr = 17'h00300; bus.len = 18'd2;
        tick(1, 0, 1, 1);
        for (int k = 1; k <= 12; k++) tick(0, 0, 1, 1);
        check_bytes("post-rst", 17'h00300, 2);
        check("post-rst done pulses", done_cyc.size(), 1);
        if (acc_addr.size() > 0) check("post-rst first addr", acc_addr[0], 17'h00300);

        check("nwe always high", nwe_viol, 0);
        check("wr_en while full", wr_full_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
